// File: rtl/audio_window_buffer_if.sv
// Purpose: bundles the capture, handshake and read-port signals of audio_window_buffer.
// Ports: capture in (i_enable/i_DATA/i_done), frame handshake (i_frame_ack/o_frame_valid/o_frame_bank),
//        read port (i_rd_addr/o_rd_data), status (o_overrun/o_peak); master = producer/consumer side, slave = buffer.
interface audio_window_buffer_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic                  i_enable;
    logic [15:0]           i_DATA;
    logic                  i_done;
    logic                  i_frame_ack;
    logic [DEPTH_LOG2-1:0] i_rd_addr;
    logic [15:0]           o_rd_data;
    logic                  o_frame_valid;
    logic                  o_frame_bank;
    logic                  o_overrun;
    logic [15:0]           o_peak;

    modport master (
        output i_enable, i_DATA, i_done, i_frame_ack, i_rd_addr,
        input  o_rd_data, o_frame_valid, o_frame_bank, o_overrun, o_peak
    );

    modport slave (
        input  i_enable, i_DATA, i_done, i_frame_ack, i_rd_addr,
        output o_rd_data, o_frame_valid, o_frame_bank, o_overrun, o_peak
    );
endinterface

// File: rtl/audio_window_buffer.sv
// Purpose: packs ADC samples into 2**DEPTH_LOG2-sample frames in a ping-pong RAM and publishes them.
// Ports: i_BCLK/i_rst (async active-high) plus audio_window_buffer_if.slave; read data 1-cycle latency.
// Backpressure: an unacked frame stalls the next completed frame in S_HOLD, further samples are dropped
// and flagged on sticky o_overrun. Macro AUDIO_PEAK_EN builds peak tracking; otherwise o_peak is 0.
module audio_window_buffer #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_BCLK,
    input  logic                  i_rst,
    audio_window_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic                  done_prev_q;
    logic                  wr_bank_q, wr_bank_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_bank_q, frame_bank_d;
    logic                  overrun_q, overrun_d;
    logic [15:0]           rd_data_q;

    logic [15:0]           mem [0:2*DEPTH-1];

    logic done_rise, accept, last, valid_after_ack, pub_fill, pub_hold, publish;

    always_comb begin
        done_rise       = bus.i_done & ~done_prev_q;
        accept          = done_rise & bus.i_enable & (state_q == S_FILL);
        last            = &wr_ptr_q;
        // An ack arriving alongside frame completion frees the slot in time for the new frame.
        valid_after_ack = frame_valid_q & ~bus.i_frame_ack;
        pub_fill        = accept & last & ~valid_after_ack;
        pub_hold        = bus.i_enable & (state_q == S_HOLD) & ~frame_valid_q;
        publish         = pub_fill | pub_hold;
    end

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_ptr_d      = wr_ptr_q;
        frame_valid_d = frame_valid_q;
        frame_bank_d  = frame_bank_q;
        overrun_d     = overrun_q;

        if (!bus.i_enable) begin
            // Discard the partial/held frame; the write bank stays put so it is refilled.
            state_d   = S_IDLE;
            wr_ptr_d  = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_ptr_d = '0;
                    state_d  = S_FILL;
                end
                S_FILL: begin
                    if (accept) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (last && valid_after_ack) state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (done_rise) overrun_d = 1'b1;
                    if (!frame_valid_q) state_d = S_FILL;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (bus.i_frame_ack) frame_valid_d = 1'b0;

        if (publish) begin
            frame_valid_d = 1'b1;
            frame_bank_d  = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            wr_ptr_d      = '0;
        end
    end

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            done_prev_q   <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_ptr_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_bank_q  <= 1'b0;
            overrun_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            done_prev_q   <= bus.i_done;
            wr_bank_q     <= wr_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_valid_q <= frame_valid_d;
            frame_bank_q  <= frame_bank_d;
            overrun_q     <= overrun_d;
            rd_data_q     <= mem[{frame_bank_q, bus.i_rd_addr}];
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge i_BCLK) begin
        if (accept) mem[{wr_bank_q, wr_ptr_q}] <= bus.i_DATA;
    end

    assign bus.o_rd_data     = rd_data_q;
    assign bus.o_frame_valid = frame_valid_q;
    assign bus.o_frame_bank  = frame_bank_q;
    assign bus.o_overrun     = overrun_q;

`ifdef AUDIO_PEAK_EN
    logic [15:0] sample_abs, peak_upd;
    logic [15:0] run_peak_q, run_peak_d;
    logic [15:0] peak_q, peak_d;

    always_comb begin
        // |x| with -32768 saturated to 32767 so the result fits 15 magnitude bits.
        if (!bus.i_DATA[15])              sample_abs = bus.i_DATA;
        else if (bus.i_DATA == 16'h8000)  sample_abs = 16'h7fff;
        else                              sample_abs = ~bus.i_DATA + 16'd1;
        peak_upd = (sample_abs > run_peak_q) ? sample_abs : run_peak_q;

        run_peak_d = run_peak_q;
        peak_d     = peak_q;
        if (!bus.i_enable || state_q == S_IDLE) run_peak_d = '0;
        else if (accept)                        run_peak_d = peak_upd;
        if (publish) begin
            // A held frame already folded its last sample in when it completed.
            peak_d     = pub_fill ? peak_upd : run_peak_q;
            run_peak_d = '0;
        end
    end

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            run_peak_q <= '0;
            peak_q     <= '0;
        end else begin
            run_peak_q <= run_peak_d;
            peak_q     <= peak_d;
        end
    end

    assign bus.o_peak = peak_q;
`else
    assign bus.o_peak = '0;
`endif
endmodule

// File: tb/tb_audio_window_buffer.sv
module tb_audio_window_buffer;
    localparam int DL    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    audio_window_buffer_if #(.DEPTH_LOG2(DL)) bus();

    audio_window_buffer #(.DEPTH_LOG2(DL)) dut (
        .i_BCLK (clk),
        .i_rst  (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb_q [$];

    function automatic logic [15:0] pk(input logic [15:0] p);
`ifdef AUDIO_PEAK_EN
        return p;
`else
        return (p == 16'hffff) ? 16'd0 : 16'd0;
`endif
    endfunction

    // One sample, i_done held high for two cycles; optionally scoreboarded as stored.
    task automatic send(input logic [15:0] v, input bit store);
        @(negedge clk);
        bus.i_DATA = v;
        bus.i_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_done = 1'b0;
        if (store) sb_q.push_back(v);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.i_frame_ack = 1'b1;
        @(negedge clk);
        bus.i_frame_ack = 1'b0;
    endtask

    // Reads the published frame and pops the expected sample for each address.
    task automatic read_and_score(input string tag);
        logic [15:0] e;
        for (int a = 0; a < DEPTH; a++) begin
            bus.i_rd_addr = a[DL-1:0];
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s rd[%0d]: got %0d, scoreboard empty", tag, a, bus.o_rd_data);
            end else begin
                e = sb_q.pop_front();
                if (bus.o_rd_data !== e) begin
                    n_fail++;
                    $display("FAIL %s rd[%0d]: got %0d expected %0d", tag, a, bus.o_rd_data, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_enable = 1'b0; bus.i_DATA = '0; bus.i_done = 1'b0;
        bus.i_frame_ack = 1'b0; bus.i_rd_addr = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.o_rd_data !== 16'd0) begin n_fail++; $display("FAIL reset rd_data: got %0d expected 0", bus.o_rd_data); end
        n_checks++; if (bus.o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %0b expected 0", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL reset bank: got %0b expected 0", bus.o_frame_bank); end
        n_checks++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %0b expected 0", bus.o_overrun); end
        n_checks++; if (bus.o_peak !== 16'd0) begin n_fail++; $display("FAIL reset peak: got %0d expected 0", bus.o_peak); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_read();
        bus.i_enable = 1'b1;
        for (int i = 1; i <= 7; i++) send(16'(i), 1'b1);
        n_checks++; if (bus.o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL fill early_valid: got %0b expected 0", bus.o_frame_valid); end
        send(16'd8, 1'b1);
        n_checks++; if (bus.o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL fill valid: got %0b expected 1", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL fill bank: got %0b expected 0", bus.o_frame_bank); end
        n_checks++; if (bus.o_peak !== pk(16'd8)) begin n_fail++; $display("FAIL fill peak: got %0d expected %0d", bus.o_peak, pk(16'd8)); end
        read_and_score("fill");
        ack_pulse();
        n_checks++; if (bus.o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL fill ack_clear: got %0b expected 0", bus.o_frame_valid); end
    endtask

    task automatic test_peak_sat();
        logic [15:0] v [8];
        v = '{16'hfffb, 16'd3, 16'h8000, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < 8; i++) send(v[i], 1'b1);
        n_checks++; if (bus.o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL sat valid: got %0b expected 1", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b1) begin n_fail++; $display("FAIL sat bank: got %0b expected 1", bus.o_frame_bank); end
        n_checks++; if (bus.o_peak !== pk(16'd32767)) begin n_fail++; $display("FAIL sat peak: got %0d expected %0d", bus.o_peak, pk(16'd32767)); end
        read_and_score("sat");
        ack_pulse();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) send(16'(100 + i), 1'b1);
        for (int i = 0; i < 8; i++) send(16'(-(200 + i)), 1'b1);
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL ovr held_bank: got %0b expected 0", bus.o_frame_bank); end
        n_checks++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr early: got %0b expected 0", bus.o_overrun); end
        send(16'h7777, 1'b0);
        send(16'h6666, 1'b0);
        n_checks++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr flag: got %0b expected 1", bus.o_overrun); end
        n_checks++; if (bus.o_peak !== pk(16'd107)) begin n_fail++; $display("FAIL ovr peakA: got %0d expected %0d", bus.o_peak, pk(16'd107)); end
        read_and_score("ovrA");
        ack_pulse();
        n_checks++; if (bus.o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL ovr gap: got %0b expected 0", bus.o_frame_valid); end
        @(negedge clk);
        n_checks++; if (bus.o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovr republish: got %0b expected 1", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b1) begin n_fail++; $display("FAIL ovr bank: got %0b expected 1", bus.o_frame_bank); end
        n_checks++; if (bus.o_peak !== pk(16'd207)) begin n_fail++; $display("FAIL ovr peakB: got %0d expected %0d", bus.o_peak, pk(16'd207)); end
        read_and_score("ovrB");
        n_checks++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr sticky: got %0b expected 1", bus.o_overrun); end
        ack_pulse();
        @(negedge clk);
        bus.i_enable = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr clear: got %0b expected 0", bus.o_overrun); end
        bus.i_enable = 1'b1;
    endtask

    task automatic test_ack_same_cycle();
        for (int i = 0; i < 8; i++) send(16'(300 + i), 1'b1);
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL same bankC: got %0b expected 0", bus.o_frame_bank); end
        read_and_score("sameC");
        for (int i = 0; i < 7; i++) send(16'(400 + i), 1'b1);
        @(negedge clk);
        bus.i_DATA = 16'd407; bus.i_done = 1'b1; bus.i_frame_ack = 1'b1;
        @(negedge clk);
        bus.i_frame_ack = 1'b0;
        sb_q.push_back(16'd407);
        n_checks++; if (bus.o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL same valid: got %0b expected 1", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b1) begin n_fail++; $display("FAIL same bank: got %0b expected 1", bus.o_frame_bank); end
        @(negedge clk);
        bus.i_done = 1'b0;
        n_checks++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL same overrun: got %0b expected 0", bus.o_overrun); end
        n_checks++; if (bus.o_peak !== pk(16'd407)) begin n_fail++; $display("FAIL same peak: got %0d expected %0d", bus.o_peak, pk(16'd407)); end
        read_and_score("sameD");
        ack_pulse();
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 5; i++) send(16'(500 + i), 1'b0);
        @(negedge clk);
        bus.i_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.i_enable = 1'b1;
        for (int i = 9; i <= 16; i++) send(16'(i), 1'b1);
        n_checks++; if (bus.o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL endrop valid: got %0b expected 1", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL endrop bank: got %0b expected 0", bus.o_frame_bank); end
        n_checks++; if (bus.o_peak !== pk(16'd16)) begin n_fail++; $display("FAIL endrop peak: got %0d expected %0d", bus.o_peak, pk(16'd16)); end
        read_and_score("endrop");
        ack_pulse();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send(16'(700 + i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.o_rd_data !== 16'd0) begin n_fail++; $display("FAIL rstmid rd_data: got %0d expected 0", bus.o_rd_data); end
        n_checks++; if (bus.o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid valid: got %0b expected 0", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL rstmid bank: got %0b expected 0", bus.o_frame_bank); end
        n_checks++; if (bus.o_overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid overrun: got %0b expected 0", bus.o_overrun); end
        n_checks++; if (bus.o_peak !== 16'd0) begin n_fail++; $display("FAIL rstmid peak: got %0d expected 0", bus.o_peak); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(600 + i), 1'b1);
        n_checks++; if (bus.o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid valid2: got %0b expected 1", bus.o_frame_valid); end
        n_checks++; if (bus.o_frame_bank !== 1'b0) begin n_fail++; $display("FAIL rstmid bank2: got %0b expected 0", bus.o_frame_bank); end
        read_and_score("rstmid");
        ack_pulse();
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_peak_sat();
        test_overrun();
        test_ack_same_cycle();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_window_buffer.md
Name: audio_window_buffer

Overview:
- Downstream consumer of the ADC controller's 16-bit left-channel samples, in the i_BCLK domain.
- Packs consecutive samples into fixed-length frames in a two-bank ping-pong RAM, then hands each completed frame to the visualiser/FFT stage through a valid/ack handshake and a random-access read port.
- Also reports the absolute peak amplitude of each published frame for the level-bar display.

Parameters:
- DEPTH_LOG2, 8, log2 of samples per frame (frame length DEPTH = 2**DEPTH_LOG2).

Ports:
- i_BCLK  in  1  clock, same bit clock that drives the ADC controller.
- i_rst  in  1  asynchronous active-high reset.
- i_enable  in  1  capture enable, driven from the same record control as the ADC controller.
- i_DATA  in  16  signed sample from the ADC controller.
- i_done  in  1  sample-ready from the ADC controller; may stay high 2+ cycles per sample.
- i_frame_ack  in  1  consumer releases the published frame (single-cycle pulse).
- i_rd_addr  in  DEPTH_LOG2  read address into the published bank.
- o_rd_data  out  16  registered read data.
- o_frame_valid  out  1  a published frame is readable.
- o_frame_bank  out  1  bank index of the published frame.
- o_overrun  out  1  sticky: samples were dropped.
- o_peak  out  16  unsigned absolute peak of the published frame.

Behaviour:
- Reset values: o_rd_data=0, o_frame_valid=0, o_frame_bank=0, o_overrun=0, o_peak=0, write bank=0, write pointer=0, state S_IDLE. RAM contents are not reset.
- Sample accept: a rising edge of i_done (registered previous i_done is 0, current is 1) while i_enable=1 and state is S_FILL. A held-high i_done counts as one sample.
- States:
  - S_IDLE: pointer=0, running peak=0. Go to S_FILL when i_enable=1.
  - S_FILL: on accept, write i_DATA to RAM[wr_bank][wr_ptr], increment wr_ptr, update running peak. On the accept at wr_ptr=DEPTH-1 the frame is complete:
    - if o_frame_valid=0 after this cycle's ack is applied: publish and stay in S_FILL;
    - otherwise go to S_HOLD.
  - S_HOLD: all accepts are dropped and set o_overrun=1. The first cycle in which o_frame_valid is 0 publishes the held bank and returns to S_FILL.
- Publish, effective the next cycle:
  - o_frame_bank<=wr_bank, o_frame_valid<=1, o_peak<=running peak;
  - wr_bank flips, wr_ptr<=0, running peak<=0.
- Handshake:
  - i_frame_ack while o_frame_valid=1 clears o_frame_valid next cycle.
  - Ack while o_frame_valid=0 is ignored.
  - Ack and frame completion in the same cycle: ack wins, publish succeeds, no S_HOLD and no overrun.
- Peak: |x| of the signed sample; -32768 saturates to 32767. Running peak = max over the frame's samples.
- Read port: o_rd_data <= RAM[o_frame_bank][i_rd_addr] every cycle, 1-cycle latency. Data is only meaningful while o_frame_valid=1.
- i_enable falling, any state:
  - next state S_IDLE; the partial or held frame is discarded and wr_bank is unchanged;
  - an already-published frame stays valid until acked;
  - o_overrun clears while i_enable=0.
- Reset mid-frame: all state returns to reset values; the partial frame is lost.
- wr_ptr wraps DEPTH-1 to 0 only via publish or S_HOLD; it never overwrites the bank being read.

Optional Feature:
- Macro AUDIO_PEAK_EN.
- Defined: peak tracking as above.
- Undefined: no peak logic is built, o_peak is tied to 0, and all other behaviour is identical.

Test Plan:
- DEPTH_LOG2=3; reset, i_enable=1, 8 samples 1..8, each with i_done high 2 cycles -> exactly 8 writes; o_frame_valid=1, o_frame_bank=0, o_peak=8; reading addr 0..7 returns 1..8 one cycle after each address.
- Samples -5, 3, -32768, 7, 0, 0, 0, 0 -> o_peak=32767.
- Frame 0 not acked, 8 more samples then 2 extra -> state S_HOLD, o_overrun=1, the 2 extras are not stored. Ack -> o_frame_valid low for 1 cycle, then high with o_frame_bank=1.
- Ack pulse in the same cycle as the 8th sample of frame 1 while frame 0 is valid -> no S_HOLD, o_overrun stays 0, o_frame_bank=1 next cycle.
- i_enable low after 5 samples, then high and 8 samples 9..16 -> published frame holds 9..16 in the same bank as the discarded partial.
- Assert i_rst during S_FILL with 4 samples stored -> all outputs are 0 immediately (asynchronous); the next full frame lands in bank 0.
